// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: debug/host access port of the register-file arbiter
interface regfile_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  adr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, we, adr, wdata, input ack, rdata);
  modport slave (input req, we, adr, wdata, output ack, rdata);
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the register file between the core pipeline and a debug port
module regfile_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_busy,
  input  logic             core_regwrite,
  input  logic [3:0]       core_rdadr,
  input  logic [31:0]      core_rd,
  input  logic [3:0]       core_rs1adr,
  input  logic [3:0]       core_rs2adr,
  output logic             core_hold,
  regfile_arbiter_if.slave dbg,
  output logic             rf_regwrite,
  output logic [3:0]       rf_rdadr,
  output logic [31:0]      rf_rd,
  output logic [3:0]       rf_rs1adr,
  output logic [3:0]       rf_rs2adr,
  input  logic [31:0]      rf_rs1
);
  localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  typedef enum logic [2:0] {IDLE, WRITE, READ, RCAP, DONE} state_t;
  state_t        state_q, state_d;
  logic [3:0]    adr_q, adr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          grant;
  always_comb begin
    grant = state_q == IDLE && dbg.req && (!core_busy || wait_q == WW'(MAX_WAIT));
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = grant ? (dbg.we ? WRITE : READ) : IDLE;
      WRITE:   state_d = DONE;
      READ:    state_d = RCAP;
      RCAP:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    wait_d = (!dbg.req || grant) ? '0
           : (state_q == IDLE && core_busy && wait_q != WW'(MAX_WAIT)) ? wait_q + WW'(1)
           : wait_q;
    adr_d = grant ? dbg.adr : adr_q;
    wdata_d = grant ? dbg.wdata : wdata_q;
    rdata_d = state_q == RCAP ? rf_rs1 : rdata_q;
    core_hold = state_q inside {WRITE, READ, RCAP};
    rf_regwrite = state_q == WRITE || (!core_hold && core_regwrite);
    rf_rdadr = state_q == WRITE ? adr_q : core_rdadr;
    rf_rd = state_q == WRITE ? wdata_q : core_rd;
    rf_rs1adr = (state_q == READ || state_q == RCAP) ? adr_q : core_rs1adr;
    rf_rs2adr = core_rs2adr;
    dbg.ack = state_q == DONE;
    dbg.rdata = rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q <= '0;
      adr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      adr_q <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: table, directed and random checks of the register-file arbiter
module tb_regfile_arbiter;
  localparam int MAX_WAIT = 15;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_busy = 1'b0;
  logic        core_regwrite = 1'b0;
  logic [3:0]  core_rdadr = '0;
  logic [31:0] core_rd = '0;
  logic [3:0]  core_rs1adr = '0;
  logic [3:0]  core_rs2adr = '0;
  logic        core_hold;
  logic        rf_regwrite;
  logic [3:0]  rf_rdadr;
  logic [31:0] rf_rd;
  logic [3:0]  rf_rs1adr;
  logic [3:0]  rf_rs2adr;
  logic [31:0] rf_rs1 = '0;
  logic [31:0] rf_mem [16] = '{default: 32'h0};
  logic [31:0] ref_rf [16] = '{default: 32'h0};
  logic [31:0] last_rd = '0;
  int checks = 0;
  int errors = 0;
  regfile_arbiter_if dbg_if ();
  regfile_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .reset(reset),
    .core_busy(core_busy),
    .core_regwrite(core_regwrite),
    .core_rdadr(core_rdadr),
    .core_rd(core_rd),
    .core_rs1adr(core_rs1adr),
    .core_rs2adr(core_rs2adr),
    .core_hold(core_hold),
    .dbg(dbg_if),
    .rf_regwrite(rf_regwrite),
    .rf_rdadr(rf_rdadr),
    .rf_rd(rf_rd),
    .rf_rs1adr(rf_rs1adr),
    .rf_rs2adr(rf_rs2adr),
    .rf_rs1(rf_rs1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!reset && rf_regwrite && rf_rdadr != 4'd0) rf_mem[rf_rdadr] <= rf_rd;
    rf_rs1 <= rf_mem[rf_rs1adr];
  end
  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wdata;
    int          busy;
    int          ack;
    int          hold;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt [11];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic txn(input logic we, input logic [3:0] adr, input logic [31:0] wdata,
                     input int busy_len, input bit noise, input bit keep,
                     input bit cw, input logic [3:0] cw_adr, input logic [31:0] cw_data,
                     output int ack_at, output int hold_first, output int hold_n,
                     output logic [31:0] rdata, output logic [31:0] snap);
    ack_at = -1;
    hold_first = -1;
    hold_n = 0;
    rdata = '0;
    snap = '0;
    @(negedge clk);
    dbg_if.req = 1'b1;
    dbg_if.we = we;
    dbg_if.adr = adr;
    dbg_if.wdata = wdata;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      core_busy = k < busy_len;
      core_rs1adr = 4'($urandom);
      core_rs2adr = 4'($urandom);
      if (dbg_if.ack) begin
        ack_at = k;
        rdata = dbg_if.rdata;
        core_regwrite = 1'b0;
        if (!keep) dbg_if.req = 1'b0;
      end else if (core_hold) begin
        if (hold_first < 0) begin
          hold_first = k;
          snap = ref_rf[adr];
        end
        hold_n++;
        dbg_if.we = ~we;
        dbg_if.adr = ~adr;
        dbg_if.wdata = ~wdata;
        core_regwrite = 1'b1;
        core_rdadr = adr;
        core_rd = 32'hBAD0_0000 + 32'(k);
      end else begin
        core_regwrite = (k == 0 && cw) || (noise && $urandom_range(0, 1) == 1);
        core_rdadr = (k == 0 && cw) ? cw_adr : 4'($urandom);
        core_rd = (k == 0 && cw) ? cw_data : $urandom;
        if (core_regwrite && core_rdadr != 4'd0) ref_rf[core_rdadr] = core_rd;
      end
      #1;
      check("rs2_pass", rf_rs2adr, core_rs2adr);
      if (!core_hold)
        check("core_pass", {rf_regwrite, rf_rdadr, rf_rd, rf_rs1adr},
              {core_regwrite, core_rdadr, core_rd, core_rs1adr});
      if (ack_at >= 0) break;
    end
    core_busy = 1'b0;
    core_regwrite = 1'b0;
    if (we && adr != 4'd0) ref_rf[adr] = wdata;
  endtask
  task automatic run(input string nm, input logic we, input logic [3:0] adr, input logic [31:0] wdata,
                     input int busy_len, input bit noise, input bit keep,
                     input bit cw, input logic [3:0] cw_adr, input logic [31:0] cw_data,
                     output logic [31:0] rd);
    int ack_at, hf, hn, g;
    logic [31:0] snap;
    g = busy_len < MAX_WAIT ? busy_len : MAX_WAIT;
    txn(we, adr, wdata, busy_len, noise, keep, cw, cw_adr, cw_data, ack_at, hf, hn, rd, snap);
    check({nm, "_ack"}, ack_at, g + (we ? 2 : 3));
    check({nm, "_hold_first"}, hf, g + 1);
    check({nm, "_hold_n"}, hn, we ? 1 : 2);
    check({nm, "_rdata"}, rd, we ? last_rd : snap);
    if (!we) last_rd = snap;
  endtask
  initial begin
    int ack_at, hf, hn;
    logic [31:0] rd, snap;
    dbg_if.req = 1'b0;
    dbg_if.we = 1'b0;
    dbg_if.adr = '0;
    dbg_if.wdata = '0;
    vt[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 0,  2,  1, 32'h0};
    vt[1]  = '{1'b0, 4'd5,  32'h0,        0,  3,  2, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 4'd0,  32'h0,        0,  3,  2, 32'h0};
    vt[3]  = '{1'b1, 4'd0,  32'h00012345, 0,  2,  1, 32'h0};
    vt[4]  = '{1'b0, 4'd0,  32'h0,        2,  5,  2, 32'h0};
    vt[5]  = '{1'b1, 4'd9,  32'hCAFEF00D, 3,  5,  1, 32'h0};
    vt[6]  = '{1'b0, 4'd9,  32'h0,        20, 18, 2, 32'hCAFEF00D};
    vt[7]  = '{1'b0, 4'd5,  32'h0,        15, 18, 2, 32'hDEADBEEF};
    vt[8]  = '{1'b0, 4'd9,  32'h0,        14, 17, 2, 32'hCAFEF00D};
    vt[9]  = '{1'b1, 4'd15, 32'hFFFFFFFF, 1,  3,  1, 32'hCAFEF00D};
    vt[10] = '{1'b0, 4'd15, 32'h0,        0,  3,  2, 32'hFFFFFFFF};
    repeat (3) @(negedge clk);
    check("rst_hold", core_hold, 1'b0);
    check("rst_ack", dbg_if.ack, 1'b0);
    check("rst_rdata", dbg_if.rdata, 32'h0);
    core_regwrite = 1'b1;
    core_rdadr = 4'd6;
    core_rd = 32'h55AA55AA;
    core_rs1adr = 4'd11;
    core_rs2adr = 4'd12;
    #1;
    check("rst_pass", {rf_regwrite, rf_rdadr, rf_rd, rf_rs1adr, rf_rs2adr},
          {core_regwrite, core_rdadr, core_rd, core_rs1adr, core_rs2adr});
    core_regwrite = 1'b0;
    reset = 1'b0;
    foreach (vt[i]) begin
      txn(vt[i].we, vt[i].adr, vt[i].wdata, vt[i].busy, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, ack_at, hf, hn, rd, snap);
      check($sformatf("vec%0d_ack", i), ack_at, vt[i].ack);
      check($sformatf("vec%0d_hold_first", i), hf, vt[i].ack - vt[i].hold);
      check($sformatf("vec%0d_hold_n", i), hn, vt[i].hold);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      last_rd = vt[i].rdata;
    end
    run("core_then_read_x7", 1'b0, 4'd7, 32'h0, 0, 1'b0, 1'b0, 1'b1, 4'd7, 32'h12345678, rd);
    check("read_x7_const", rd, 32'h12345678);
    run("contention_wr_x3", 1'b1, 4'd3, 32'h2, 0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h1, rd);
    run("contention_rd_x3", 1'b0, 4'd3, 32'h0, 0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, rd);
    check("contention_x3_const", rd, 32'h2);
    run("held_first", 1'b0, 4'd5, 32'h0, 0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0, rd);
    run("held_second", 1'b0, 4'd9, 32'h0, 0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, rd);
    check("held_second_const", rd, 32'hCAFEF00D);
    @(negedge clk);
    dbg_if.req = 1'b1;
    dbg_if.we = 1'b0;
    dbg_if.adr = 4'd5;
    repeat (2) @(negedge clk);
    check("mid_rcap_hold", core_hold, 1'b1);
    reset = 1'b1;
    dbg_if.req = 1'b0;
    @(negedge clk);
    check("mid_rst_hold", core_hold, 1'b0);
    check("mid_rst_ack", dbg_if.ack, 1'b0);
    check("mid_rst_rdata", dbg_if.rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_no_ack", dbg_if.ack, 1'b0);
    last_rd = '0;
    for (int n = 0; n < 40; n++)
      run($sformatf("rand%0d", n), 1'($urandom), 4'($urandom), $urandom,
          int'($urandom_range(0, 20)), 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, rd);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
